dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the multicycle PhilosophyV core. It serves load/store requests issued by the control FSM during its MEMORY state and drives a synchronous byte-writable block RAM. It handles RV32I funct3 width selection, byte-lane steering, sign/zero extension and misalignment faults, and returns exactly one response per accepted request.

## Interface
- `ADDR_WIDTH`, default 12: byte-address bits decoded. The RAM is indexed by word address `[ADDR_WIDTH-1:2]`. Upper address bits are ignored, so the space aliases.
- `READ_LATENCY`, default 1: RAM read latency in cycles. Legal values are 1..3.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access width and signedness (RV32I encoding).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (rs2).
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_fault`  out  1  qualifies `resp_valid`: misaligned address or illegal funct3.
- `resp_rdata`  out  32  extended load data, held until the next load response.
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  4  per-byte write enables.
- `mem_addr`  out  ADDR_WIDTH-2  word address.
- `mem_wdata`  out  32  lane-steered store data.
- `mem_rdata`  in  32  RAM read data.

## Operation
- **FSM states**: IDLE, ACCESS, WAIT, RESP.
- **IDLE**:
  - `req_ready`=1.
  - `req_valid` with `req_ready` accepts the request. It latches we, funct3, addr and wdata.
  - A faulting request goes to RESP with the fault flag set; otherwise go to ACCESS.
  - `req_valid` in any other state is ignored. It is not queued.
- **Fault conditions**:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ∉ {000,001,010}.
  - A faulting request produces no RAM activity.
- **ACCESS**: one cycle.
  - `mem_en`=1, `mem_addr` from the latched address.
  - Stores: `mem_we` lanes and `mem_wdata`, then go to RESP.
  - Loads: `mem_we`=0, counter loaded with READ_LATENCY, then go to WAIT.
- **Store steering**:
  - SB: data {4{b}}, we = 0001 << addr[1:0].
  - SH: data {2{h}}, we = 0011 or 1100 by addr[1].
  - SW: we = 1111.
- **WAIT**:
  - Counter decrements each cycle.
  - In the cycle it reads 1, `mem_rdata` is valid. It is shifted right by 8·addr[1:0], extended per funct3 (LB/LH sign, LBU/LHU zero, LW none), registered into `resp_rdata`, then go to RESP.
- **RESP**:
  - `resp_valid`=1 for one cycle; `resp_fault` reflects the latched fault.
  - Then go to IDLE.
  - There is no backpressure: the consumer must sample `resp_valid` the cycle it is high.
- `resp_rdata` is unchanged by store or fault responses.

## Timing
- Request accepted at edge T.
- **Fault**: `resp_valid` in cycle T+1.
- **Store**: `mem_en`/`mem_we` in cycle T+1; `resp_valid` in cycle T+2.
- **Load**: `mem_en` in cycle T+1; `resp_valid` in cycle T+2+READ_LATENCY.
- Next `req_ready` is the cycle after `resp_valid`. No back-to-back acceptance.
- **Reset values**: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Reset mid-operation**:
  - FSM returns to IDLE and no response is issued.
  - `mem_en` and `mem_we` are gated combinationally by `!rst`, so a store whose ACCESS cycle coincides with `rst`=1 does not commit.
- **`req_valid` and `rst` in the same cycle**: the request is dropped.

## Structure
- State encodings go in a new `mem_state_defines.h`.
- funct3 load/store codes are added to `funct_defines.h`.
- The RAM itself is external.
- Sub-module `dmem_load_align`: combinational shift and extend from (rdata, addr[1:0], funct3).
- Store lane steering stays inline.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF → cycle T+1: `mem_we`=1111, `mem_addr`=4, `mem_wdata`=0xDEADBEEF; `resp_valid` at T+2 with `resp_fault`=0.
- After the above, LB 0x13 → `resp_rdata`=0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF. Each `resp_valid` arrives at T+3 with READ_LATENCY=1.
- SB 0x21 data 0x000000A5 → `mem_we`=0010, `mem_wdata`=0xA5A5A5A5. SH 0x22 data 0x1234 → `mem_we`=1100, `mem_wdata`=0x12341234.
- LW 0x02, SH 0x05 and load funct3=011 → each gives `resp_valid` with `resp_fault`=1 at T+1, `mem_en` never asserted, and `resp_rdata` unchanged.
- Assert `rst` during a store's ACCESS cycle → `mem_we`=0 that cycle, no `resp_valid`, and a later LW of the same word returns its old contents. Repeat loads with READ_LATENCY=3 → `resp_valid` at T+5.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states,
// RV32I load/store funct3 codes and the request fault check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic req_fault(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic bad_f3;
    logic mis;
    if (we)
      bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
    else
      bad_f3 = !(f3 inside {F3_B, F3_H, F3_W,
                            F3_BU, F3_HU});
    // bit pattern 01 = halfword, 10 = word
    mis = ((f3[1:0] == 2'b01) && a[0]) ||
          ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_f3 || mis;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: shift the addressed lane down and
// sign/zero extend it according to funct3.
module dmem_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] sh;

  assign sh = rdata >> {addr, 3'b000};

  always_comb begin
    data = sh;
    case (funct3)
      F3_B:  data = {{24{sh[7]}}, sh[7:0]};
      F3_H:  data = {{16{sh[15]}}, sh[15:0]};
      F3_BU: data = {24'd0, sh[7:0]};
      F3_HU: data = {16'd0, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per request against a
// synchronous byte-writable RAM, one response per request.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_fault,
  output logic [31:0]           resp_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  mem_state_e            state;
  mem_state_e            nxt;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  fault_q;
  logic [1:0]            cnt;
  logic [31:0]           ld_data;
  logic [3:0]            lanes;
  logic [31:0]           sdata;
  logic                  accept;
  logic                  req_bad;
  logic                  unused_addr;

  // the address space aliases above ADDR_WIDTH
  assign unused_addr = ^req_addr[31:ADDR_WIDTH];

  assign accept  = req_valid && (state == S_IDLE);
  assign req_bad = req_fault(req_we, req_funct3,
                             req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (accept) nxt = req_bad ? S_RESP : S_ACCESS;
      S_ACCESS:
        nxt = we_q ? S_RESP : S_WAIT;
      S_WAIT:
        if (cnt == 2'd1) nxt = S_RESP;
      S_RESP:
        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    resp_fault = (state == S_RESP) && fault_q;
    mem_en     = (state == S_ACCESS) && !rst;
    mem_we     = 4'b0000;
    if ((state == S_ACCESS) && we_q && !rst)
      mem_we = lanes;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      fault_q    <= 1'b0;
      cnt        <= 2'd0;
      resp_rdata <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[ADDR_WIDTH-1:0];
        wdata_q <= req_wdata;
        fault_q <= req_bad;
      end
      if (state == S_ACCESS)
        cnt <= 2'(READ_LATENCY);
      if (state == S_WAIT) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) resp_rdata <= ld_data;
      end
    end
  end

  always_comb begin
    lanes = 4'b0000;
    sdata = wdata_q;
    unique case (1'b1)
      (f3_q == F3_B): begin
        lanes = 4'b0001 << addr_q[1:0];
        sdata = {4{wdata_q[7:0]}};
      end
      (f3_q == F3_H): begin
        lanes = addr_q[1] ? 4'b1100 : 4'b0011;
        sdata = {2{wdata_q[15:0]}};
      end
      (f3_q == F3_W): begin
        lanes = 4'b1111;
        sdata = wdata_q;
      end
      default: begin
        lanes = 4'b0000;
        sdata = wdata_q;
      end
    endcase
  end

  assign mem_addr  = addr_q[ADDR_WIDTH-1:2];
  assign mem_wdata = sdata;

  dmem_load_align u_align (
    .rdata  (mem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (read
// latency 1 and 3) share stimulus, each with its own RAM.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready1, resp_valid1, resp_fault1;
  logic [31:0] resp_rdata1, mem_wdata1, mem_rdata1;
  logic        mem_en1;
  logic [3:0]  mem_we1;
  logic [9:0]  mem_addr1;

  logic        req_ready3, resp_valid3, resp_fault3;
  logic [31:0] resp_rdata3, mem_wdata3, mem_rdata3;
  logic        mem_en3;
  logic [3:0]  mem_we3;
  logic [9:0]  mem_addr3;

  logic [31:0] ram1 [0:1023];
  logic [31:0] ram3 [0:1023];
  logic [31:0] p1;
  logic [31:0] p3 [0:2];

  int checks = 0;
  int errors = 0;
  int cur = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(12), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_fault(resp_fault1),
    .resp_rdata(resp_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  dmem_responder #(.ADDR_WIDTH(12), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready3),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_fault(resp_fault3),
    .resp_rdata(resp_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  always @(posedge clk) begin
    if (mem_en1) begin
      p1 <= ram1[mem_addr1];
      for (int b = 0; b < 4; b++)
        if (mem_we1[b])
          ram1[mem_addr1][8*b +: 8] <= mem_wdata1[8*b +: 8];
    end
  end
  assign mem_rdata1 = p1;

  always @(posedge clk) begin
    if (mem_en3) begin
      p3[0] <= ram3[mem_addr3];
      for (int b = 0; b < 4; b++)
        if (mem_we3[b])
          ram3[mem_addr3][8*b +: 8] <= mem_wdata3[8*b +: 8];
    end
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [3:0]  mwe;
    logic [9:0]  maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h",
               nm, cur, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    int lat1, lat3, en1, en3;
    int exp1, exp3;
    logic f1, f3;
    logic [31:0] rd1, rd3, exp_rd;
    logic a_en1;
    logic [3:0] a_we1, a_we3;
    logic [9:0] a_addr1;
    logic [31:0] a_wd1, a_wd3;
    exp1 = v.fault ? 1 : (v.we ? 2 : 3);
    exp3 = v.fault ? 1 : (v.we ? 2 : 5);
    exp_rd = (!v.fault && !v.we) ? v.rdata : last_rd;
    lat1 = 0; lat3 = 0; en1 = 0; en3 = 0;
    f1 = 1'b0; f3 = 1'b0; rd1 = '0; rd3 = '0;
    a_en1 = 1'b0; a_we1 = '0; a_we3 = '0;
    a_addr1 = '0; a_wd1 = '0; a_wd3 = '0;
    @(negedge clk);
    chk("ready1", req_ready1, 1'b1);
    chk("ready3", req_ready3, 1'b1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_en1) en1++;
      if (mem_en3) en3++;
      if (k == 1) begin
        a_en1 = mem_en1; a_we1 = mem_we1;
        a_we3 = mem_we3; a_addr1 = mem_addr1;
        a_wd1 = mem_wdata1; a_wd3 = mem_wdata3;
      end
      if (resp_valid1 && lat1 == 0) begin
        lat1 = k; f1 = resp_fault1; rd1 = resp_rdata1;
      end
      if (resp_valid3 && lat3 == 0) begin
        lat3 = k; f3 = resp_fault3; rd3 = resp_rdata3;
      end
      if (lat1 != 0 && lat3 != 0) break;
    end
    chk("lat1", lat1, exp1);
    chk("lat3", lat3, exp3);
    chk("fault1", f1, v.fault);
    chk("fault3", f3, v.fault);
    chk("rdata1", rd1, exp_rd);
    chk("rdata3", rd3, exp_rd);
    chk("en_count1", en1, v.fault ? 0 : 1);
    chk("en_count3", en3, v.fault ? 0 : 1);
    if (!v.fault) begin
      chk("access_en", a_en1, 1'b1);
      chk("mem_we1", a_we1, v.mwe);
      chk("mem_we3", a_we3, v.mwe);
      chk("mem_addr", a_addr1, v.maddr);
      if (v.we) begin
        chk("mem_wdata1", a_wd1, v.mwdata);
        chk("mem_wdata3", a_wd3, v.mwdata);
      end
    end
    last_rd = exp_rd;
  endtask

  initial begin
    int hits;
    vecs[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0,
                 4'hF, 10'd4, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 3'd0, 32'h13, 32'h0, 1'b0,
                 4'h0, 10'd4, 32'h0, 32'hFFFFFFDE};
    vecs[2]  = '{1'b0, 3'd4, 32'h13, 32'h0, 1'b0,
                 4'h0, 10'd4, 32'h0, 32'h000000DE};
    vecs[3]  = '{1'b0, 3'd1, 32'h12, 32'h0, 1'b0,
                 4'h0, 10'd4, 32'h0, 32'hFFFFDEAD};
    vecs[4]  = '{1'b0, 3'd5, 32'h10, 32'h0, 1'b0,
                 4'h0, 10'd4, 32'h0, 32'h0000BEEF};
    vecs[5]  = '{1'b1, 3'd2, 32'h20, 32'h0, 1'b0,
                 4'hF, 10'd8, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 3'd0, 32'h21, 32'hA5, 1'b0,
                 4'h2, 10'd8, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{1'b1, 3'd1, 32'h22, 32'h1234, 1'b0,
                 4'hC, 10'd8, 32'h12341234, 32'h0};
    vecs[8]  = '{1'b0, 3'd2, 32'h20, 32'h0, 1'b0,
                 4'h0, 10'd8, 32'h0, 32'h1234A500};
    vecs[9]  = '{1'b0, 3'd0, 32'h21, 32'h0, 1'b0,
                 4'h0, 10'd8, 32'h0, 32'hFFFFFFA5};
    vecs[10] = '{1'b0, 3'd2, 32'h02, 32'h0, 1'b1,
                 4'h0, 10'd0, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 3'd1, 32'h05, 32'h55, 1'b1,
                 4'h0, 10'd0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 3'd3, 32'h00, 32'h0, 1'b1,
                 4'h0, 10'd0, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 3'd4, 32'h00, 32'h77, 1'b1,
                 4'h0, 10'd0, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 3'd1, 32'h23, 32'h0, 1'b1,
                 4'h0, 10'd0, 32'h0, 32'h0};
    vecs[15] = '{1'b0, 3'd5, 32'h22, 32'h0, 1'b0,
                 4'h0, 10'd8, 32'h0, 32'h00001234};
    vecs[16] = '{1'b0, 3'd4, 32'h22, 32'h0, 1'b0,
                 4'h0, 10'd8, 32'h0, 32'h00000034};
    vecs[17] = '{1'b0, 3'd2, 32'h1010, 32'h0, 1'b0,
                 4'h0, 10'd4, 32'h0, 32'hDEADBEEF};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    last_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready1, 1'b1);
    chk("rst_resp_valid", resp_valid1, 1'b0);
    chk("rst_resp_fault", resp_fault1, 1'b0);
    chk("rst_rdata", resp_rdata1, 32'h0);
    chk("rst_mem_en", mem_en1, 1'b0);
    chk("rst_mem_we", mem_we1, 4'h0);
    chk("rst_mem_addr", mem_addr1, 10'h0);
    chk("rst_mem_wdata", mem_wdata1, 32'h0);
    chk("rst_rdata3", resp_rdata3, 32'h0);

    for (int i = 0; i < 18; i++) begin
      cur = i;
      run_req(vecs[i]);
    end

    // reset lands on the ACCESS cycle of a store
    cur = 100;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h10; req_wdata = 32'h11111111;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstacc_mem_we1", mem_we1, 4'h0);
    chk("rstacc_mem_we3", mem_we3, 4'h0);
    chk("rstacc_mem_en", mem_en1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid1 || resp_valid3) hits++;
    end
    chk("rstacc_no_resp", hits, 0);
    chk("rstacc_rdata", resp_rdata1, 32'h0);
    last_rd = 32'h0;
    cur = 101;
    run_req(vecs[17]);

    // request and reset in the same cycle
    cur = 102;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h10; req_wdata = 32'h22222222;
    rst = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b0;
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_en1 || mem_en3 || resp_valid1) hits++;
    end
    chk("rstreq_dropped", hits, 0);
    last_rd = 32'h0;
    cur = 103;
    run_req(vecs[0 + 17]);
    cur = 104;
    run_req(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
